// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the 5-stage core. Captures the decoded control
//   bundle, register-file operands, immediate and register specifiers every
//   cycle. Detects load-use hazards between the instruction in ID and a load
//   in EX, inserts a single bubble and holds the front end. A saturating
//   counter records how many hazard bubbles were inserted.
//
// Ports
//   clk, rst                     rising-edge clock, async active-high reset
//   id_opcode                    opcode of the instruction in ID
//   id_RegDst .. id_MemtoReg     decoded control bits
//   id_ALUOp                     decoded ALU operation class
//   id_rdata1, id_rdata2         register-file read data
//   id_imm                       sign-extended immediate
//   id_rs, id_rt, id_rd          register specifiers
//   id_funct                     function field
//   flush                        load a bubble instead of the ID instruction
//   stall_in                     downstream hold request, freezes the stage
//   ex_*                         registered copies of the id_* fields
//   ex_valid                     EX slot holds a real instruction
//   pc_write, if_id_write        front-end enables (combinational)
//   bubble_cnt                   saturating count of hazard bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [5:0]        id_opcode,
  input  logic              id_RegDst,
  input  logic              id_RegWrite,
  input  logic              id_ALUSrc,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  input  logic              stall_in,

  output logic              ex_RegDst,
  output logic              ex_RegWrite,
  output logic              ex_ALUSrc,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [5:0]        ex_funct,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000100,
    OP_ADDI  = 6'b001100,
    OP_SUBI  = 6'b001101,
    OP_SW    = 6'b010000,
    OP_LW    = 6'b010001
  } opcode_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t ctrl_q;
  ctrl_t ctrl_in;
  logic  op_valid;
  logic  rt_used;
  logic  hazard;
  logic  take_bubble;

  // ---------------------------------------------------------------------------
  // Opcode classification: which opcodes are real, and which read rt.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case so that no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    op_valid = 1'b0;
    rt_used  = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin op_valid = 1'b1; rt_used = 1'b1; end
      OP_SW:    begin op_valid = 1'b1; rt_used = 1'b1; end
      OP_ADDI,
      OP_SUBI,
      OP_LW:    op_valid = 1'b1;
      default:  ;
    endcase
  end

  // An unknown opcode must never carry a side effect into EX, regardless of
  // what the control decoder produced for it.
  always_comb begin
    ctrl_in = '0;
    if (op_valid) begin
      ctrl_in.reg_dst    = id_RegDst;
      ctrl_in.reg_write  = id_RegWrite;
      ctrl_in.alu_src    = id_ALUSrc;
      ctrl_in.mem_write  = id_MemWrite;
      ctrl_in.mem_read   = id_MemRead;
      ctrl_in.mem_to_reg = id_MemtoReg;
      ctrl_in.alu_op     = id_ALUOp;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use detection. rs is read by every valid opcode; rt only by R-type
  // and sw (for the immediate forms and lw, rt is the destination). Register
  // 0 is hard-wired, so a load targeting it never creates a dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard = 1'b0;
    if (ex_valid && ctrl_q.mem_read && (ex_rt != 5'd0)) begin
      hazard = ((ex_rt == id_rs) && op_valid) ||
               ((ex_rt == id_rt) && rt_used);
    end
  end

  assign pc_write    = ~(hazard | stall_in);
  assign if_id_write = ~(hazard | stall_in);

  // flush has priority over hazard when both are present; either one loads a
  // bubble, but only a hazard-caused bubble is counted.
  assign take_bubble = flush | hazard;

  // ---------------------------------------------------------------------------
  // Control bundle, valid bit and bubble counter.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (!stall_in) begin
      if (take_bubble) begin
        ctrl_q   <= '0;
        ex_valid <= 1'b0;
        if (!flush && (bubble_cnt != CNT_MAX)) begin
          bubble_cnt <= bubble_cnt + CNT_ONE;
        end
      end else begin
        ctrl_q   <= ctrl_in;
        ex_valid <= op_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath fields. They are don't-care behind a bubble, so they simply load
  // whenever the stage is not held; only stall_in freezes them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
    end else if (!stall_in) begin
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_funct  <= id_funct;
    end
  end

  assign ex_RegDst   = ctrl_q.reg_dst;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A behavioural model of the EX slot
//   (valid flag, control vector, datapath fields, bubble counts) predicts every
//   registered output and the front-end enables. A second instance with a
//   2-bit counter, fed the same inputs, exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DW = 32;

  localparam logic [5:0] OP_R    = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001100;
  localparam logic [5:0] OP_SUBI = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]    id_opcode;
  logic          id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemRead, id_MemtoReg;
  logic [1:0]    id_ALUOp;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [5:0]    id_funct;
  logic          flush, stall_in;

  logic          ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg;
  logic [1:0]    ex_ALUOp;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [5:0]    ex_funct;
  logic          ex_valid, pc_write, if_id_write;
  logic [15:0]   bubble_cnt;

  logic          s_RegDst, s_RegWrite, s_ALUSrc, s_MemWrite, s_MemRead, s_MemtoReg;
  logic [1:0]    s_ALUOp;
  logic [DW-1:0] s_rdata1, s_rdata2, s_imm;
  logic [4:0]    s_rs, s_rt, s_rd;
  logic [5:0]    s_funct;
  logic          s_valid, s_pc_write, s_if_id_write;
  logic [1:0]    s_bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
    .id_ALUSrc(id_ALUSrc), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
    .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .stall_in(stall_in),
    .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUOp(ex_ALUOp), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
    .id_ALUSrc(id_ALUSrc), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
    .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .stall_in(stall_in),
    .ex_RegDst(s_RegDst), .ex_RegWrite(s_RegWrite), .ex_ALUSrc(s_ALUSrc),
    .ex_MemWrite(s_MemWrite), .ex_MemRead(s_MemRead), .ex_MemtoReg(s_MemtoReg),
    .ex_ALUOp(s_ALUOp), .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_valid(s_valid), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .bubble_cnt(s_bubble_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------- model ----
  // Control vector layout: {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, ALUOp}
  bit           m_valid;
  logic [7:0]   m_ctrl;
  logic [116:0] m_dp;       // {rdata1, rdata2, imm, rs, rt, rd, funct}
  bit           m_dp_known;
  logic [4:0]   m_rt;
  int unsigned  m_cnt, m_cnt2;

  function automatic bit is_valid_op(logic [5:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SW) || (op == OP_LW);
  endfunction

  function automatic bit reads_rt(logic [5:0] op);
    return (op == OP_R) || (op == OP_SW);
  endfunction

  function automatic logic [7:0] natural_ctrl(logic [5:0] op);
    case (op)
      OP_R:    return 8'b1100_0010;
      OP_ADDI: return 8'b0110_0000;
      OP_SUBI: return 8'b0110_0001;
      OP_SW:   return 8'b0011_0000;
      OP_LW:   return 8'b0110_1100;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic bit model_hazard();
    bit load_in_ex;
    load_in_ex = m_valid && m_ctrl[3] && (m_rt != 5'd0);
    return load_in_ex && (((m_rt == id_rs) && is_valid_op(id_opcode)) ||
                          ((m_rt == id_rt) && reads_rt(id_opcode)));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = '0; m_dp = '0; m_dp_known = 1; m_rt = '0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  // ------------------------------------------------------------- stimulus ----
  task automatic drive(logic [5:0] op, logic [7:0] ctrl, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic [DW-1:0] r1, logic [DW-1:0] r2,
                       logic [DW-1:0] imm, logic [5:0] funct);
    id_opcode = op;
    {id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemRead, id_MemtoReg, id_ALUOp} = ctrl;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_funct = funct;
  endtask

  task automatic drive_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    drive(op, natural_ctrl(op), rs, rt, rd, $urandom, $urandom, $urandom, 6'($urandom));
  endtask

  // One clock: check the enables against the model before the edge, advance
  // the model by the priority rules, then check the registered outputs.
  task automatic step();
    bit          haz, en;
    logic [7:0]  got_ctrl;
    logic [116:0] got_dp;
    #1;
    haz = model_hazard();
    en  = !(haz || stall_in);
    checks++;
    if (pc_write !== en) begin
      failures++;
      $display("FAIL pc_write t=%0t got=%b exp=%b", $time, pc_write, en);
    end
    checks++;
    if (if_id_write !== en) begin
      failures++;
      $display("FAIL if_id_write t=%0t got=%b exp=%b", $time, if_id_write, en);
    end
    @(posedge clk);
    if (!stall_in) begin
      if (flush || haz) begin
        m_valid = 0; m_ctrl = '0; m_dp_known = 0;
        if (!flush) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end else begin
        m_valid    = is_valid_op(id_opcode);
        m_ctrl     = m_valid ? {id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite,
                                id_MemRead, id_MemtoReg, id_ALUOp} : 8'h00;
        m_dp       = {id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd, id_funct};
        m_dp_known = 1;
        m_rt       = id_rt;
      end
    end
    #1;
    got_ctrl = {ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_ALUOp};
    got_dp   = {ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct};
    checks++;
    if (ex_valid !== m_valid) begin
      failures++;
      $display("FAIL ex_valid t=%0t got=%b exp=%b", $time, ex_valid, m_valid);
    end
    checks++;
    if (got_ctrl !== m_ctrl) begin
      failures++;
      $display("FAIL ex_ctrl t=%0t got=%b exp=%b", $time, got_ctrl, m_ctrl);
    end
    checks++;
    if (bubble_cnt !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL bubble_cnt t=%0t got=%0d exp=%0d", $time, bubble_cnt, m_cnt);
    end
    checks++;
    if (s_bubble_cnt !== 2'(m_cnt2)) begin
      failures++;
      $display("FAIL sat_bubble_cnt t=%0t got=%0d exp=%0d", $time, s_bubble_cnt, m_cnt2);
    end
    if (m_dp_known) begin
      checks++;
      if (got_dp !== m_dp) begin
        failures++;
        $display("FAIL ex_datapath t=%0t got=%h exp=%h", $time, got_dp, m_dp);
      end
    end
  endtask

  // Put an invalid instruction in EX so the next directed test starts clean.
  task automatic nop();
    flush = 0; stall_in = 0;
    drive(6'b000000, 8'h00, 5'd0, 5'd0, 5'd0, '0, '0, '0, 6'd0);
    step();
  endtask

  // ---------------------------------------------------------------- tests ----
  task automatic test_reset();
    rst = 1; flush = 0; stall_in = 0;
    drive(6'b000000, 8'h00, 5'd0, 5'd0, 5'd0, '0, '0, '0, 6'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ex_valid, ex_RegWrite, ex_MemRead, ex_rdata1, ex_rt, bubble_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b rw=%b mr=%b r1=%h rt=%0d cnt=%0d exp all 0",
               ex_valid, ex_RegWrite, ex_MemRead, ex_rdata1, ex_rt, bubble_cnt);
    end
    checks++;
    if (pc_write !== 1'b1) begin
      failures++;
      $display("FAIL reset_pc_write got=%b exp=1", pc_write);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_normal();
    nop();
    drive(OP_R, natural_ctrl(OP_R), 5'd1, 5'd2, 5'd3, 32'h5, 32'h3, 32'h0, 6'h20);
    step();
    checks++;
    if ({ex_RegDst, ex_RegWrite, ex_ALUOp, ex_rdata1, ex_rd, ex_valid} !== {1'b1, 1'b1, 2'b10, 32'h5, 5'd3, 1'b1}) begin
      failures++;
      $display("FAIL normal_load got regdst=%b rw=%b aluop=%b r1=%h rd=%0d valid=%b exp 1 1 10 5 3 1",
               ex_RegDst, ex_RegWrite, ex_ALUOp, ex_rdata1, ex_rd, ex_valid);
    end
  endtask

  task automatic test_load_use();
    int unsigned cnt0;
    nop();
    drive_op(OP_LW, 5'd1, 5'd4, 5'd0);
    step();
    drive_op(OP_ADDI, 5'd4, 5'd9, 5'd0);
    #1;
    checks++;
    if ({pc_write, if_id_write} !== 2'b00) begin
      failures++;
      $display("FAIL load_use_enables got=%b%b exp=00", pc_write, if_id_write);
    end
    cnt0 = m_cnt;
    step();
    checks++;
    if ({ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead} !== 4'b0000 || bubble_cnt !== 16'(cnt0 + 1)) begin
      failures++;
      $display("FAIL load_use_bubble got valid=%b rw=%b mw=%b mr=%b cnt=%0d exp 0 0 0 0 %0d",
               ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, bubble_cnt, cnt0 + 1);
    end
    step();
    checks++;
    if ({ex_valid, ex_rs, ex_RegWrite} !== {1'b1, 5'd4, 1'b1}) begin
      failures++;
      $display("FAIL load_use_issue got valid=%b rs=%0d rw=%b exp 1 4 1", ex_valid, ex_rs, ex_RegWrite);
    end
  endtask

  task automatic test_non_source();
    nop();
    drive_op(OP_LW, 5'd1, 5'd4, 5'd0);
    step();
    drive_op(OP_ADDI, 5'd7, 5'd4, 5'd0);
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      failures++;
      $display("FAIL addi_rt_not_source got pc_write=%b exp=1", pc_write);
    end
    step();
    drive_op(OP_LW, 5'd1, 5'd4, 5'd0);
    step();
    drive_op(OP_SW, 5'd7, 5'd4, 5'd0);
    #1;
    checks++;
    if (pc_write !== 1'b0) begin
      failures++;
      $display("FAIL sw_rt_source got pc_write=%b exp=0", pc_write);
    end
    step();
    step();
    drive_op(OP_LW, 5'd1, 5'd0, 5'd0);
    step();
    drive_op(OP_R, 5'd0, 5'd0, 5'd5);
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      failures++;
      $display("FAIL r0_not_hazard got pc_write=%b exp=1", pc_write);
    end
    step();
  endtask

  task automatic test_stall();
    int unsigned cnt0;
    nop();
    drive(OP_R, natural_ctrl(OP_R), 5'd8, 5'd9, 5'd10, 32'hCAFE_0001, 32'h1234, 32'h0, 6'h22);
    step();
    cnt0 = m_cnt;
    stall_in = 1;
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) flush = 1;
      drive_op(OP_LW, 5'($urandom), 5'($urandom), 5'($urandom));
      step();
      checks++;
      if ({ex_valid, ex_rdata1, ex_rd, bubble_cnt} !== {1'b1, 32'hCAFE_0001, 5'd10, 16'(cnt0)}) begin
        failures++;
        $display("FAIL stall_hold i=%0d got valid=%b r1=%h rd=%0d cnt=%0d exp 1 cafe0001 10 %0d",
                 i, ex_valid, ex_rdata1, ex_rd, bubble_cnt, cnt0);
      end
    end
    stall_in = 0;
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_after_stall got valid=%b exp=0", ex_valid);
    end
    flush = 0;
  endtask

  task automatic test_flush_hazard();
    int unsigned cnt0;
    nop();
    drive_op(OP_LW, 5'd2, 5'd6, 5'd0);
    step();
    drive_op(OP_ADDI, 5'd6, 5'd1, 5'd0);
    flush = 1;
    cnt0 = m_cnt;
    step();
    checks++;
    if ({ex_valid, ex_RegWrite, bubble_cnt} !== {1'b0, 1'b0, 16'(cnt0)}) begin
      failures++;
      $display("FAIL flush_wins got valid=%b rw=%b cnt=%0d exp 0 0 %0d", ex_valid, ex_RegWrite, bubble_cnt, cnt0);
    end
    flush = 0;
    step();
  endtask

  task automatic test_invalid();
    nop();
    drive(6'b111111, 8'hFF, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 6'h3F);
    step();
    checks++;
    if ({ex_valid, ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_ALUOp} !== 9'b0) begin
      failures++;
      $display("FAIL invalid_opcode got valid=%b rw=%b mw=%b mr=%b exp all 0",
               ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      nop();
      drive_op(OP_LW, 5'd1, 5'd5, 5'd0);
      step();
      drive_op(OP_ADDI, 5'd5, 5'd2, 5'd0);
      step();
      step();
    end
    checks++;
    if (s_bubble_cnt !== 2'b11) begin
      failures++;
      $display("FAIL saturation got=%0d exp=3", s_bubble_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_SUBI;
    ops[3] = OP_SW; ops[4] = OP_LW;  ops[5] = 6'($urandom);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0)
        drive(op, 8'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom), $urandom, $urandom, $urandom, 6'($urandom));
      else
        drive_op(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      flush    = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 9) == 0);
      step();
    end
    flush = 0; stall_in = 0;
  endtask

  task automatic test_reset_mid_stall();
    nop();
    drive_op(OP_R, 5'd1, 5'd2, 5'd3);
    step();
    stall_in = 1;
    step();
    #2;
    rst = 1;
    #1;
    model_reset();
    checks++;
    if ({ex_valid, ex_RegWrite, ex_RegDst, ex_ALUOp, ex_rdata1, ex_rd, bubble_cnt, pc_write} !== '0) begin
      failures++;
      $display("FAIL async_reset got valid=%b rw=%b aluop=%b r1=%h rd=%0d cnt=%0d pcw=%b exp all 0",
               ex_valid, ex_RegWrite, ex_ALUOp, ex_rdata1, ex_rd, bubble_cnt, pc_write);
    end
    stall_in = 0;
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_pc_write got=%b exp=1", pc_write);
    end
    @(negedge clk);
    rst = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_non_source();
    test_stall();
    test_flush_hazard();
    test_invalid();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage core, directly downstream of the opcode decoder (Control) and register file. It captures the decoded control bundle, the operands and the register specifiers each cycle. It detects load-use hazards against the instruction currently in EX, inserts a bubble and stalls the front end. A saturating counter tracks the number of inserted bubbles for performance debug.

Parameters:
DATA_W, 32, width of the register-file operands and the sign-extended immediate
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_opcode  in  6  opcode of the instruction in ID (R_type 000100, addi 001100, subi 001101, sw 010000, lw 010001)
id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemRead, id_MemtoReg  in  1 each  decoded control signals
id_ALUOp  in  2  decoded ALU operation class
id_rdata1, id_rdata2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  5 each  register specifiers
id_funct  in  6  function field
flush  in  1  discard the instruction in ID (load a bubble)
stall_in  in  1  downstream hold request (e.g. memory wait)
ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg  out  1 each  registered control signals
ex_ALUOp  out  2  registered ALU operation class
ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered operands
ex_rs, ex_rt, ex_rd  out  5 each  registered register specifiers
ex_funct  out  6  registered function field
ex_valid  out  1  EX slot holds a real instruction
pc_write  out  1  PC may advance (combinational)
if_id_write  out  1  IF/ID register may load (combinational)
bubble_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every registered output is 0, ex_valid is 0, bubble_cnt is 0.
- Valid opcode: one of the five listed opcodes. Any other opcode is loaded with all control outputs 0 and ex_valid=0, whatever the id_* control inputs hold.
- Source use:
  - rs is a source for every valid opcode.
  - rt is a source only for R_type and sw.
- Hazard (combinational): hazard = ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs & rs used) | (ex_rt == id_rt & rt used)).
- Front-end enables: pc_write = if_id_write = ~(hazard | stall_in).
- Per-edge priority, highest first:
  1. rst.
  2. stall_in=1: all ID/EX registers hold and bubble_cnt holds. flush is ignored while stall_in=1, and the requester must keep flush asserted.
  3. flush=1: bubble loaded (all control outputs 0, ex_valid=0). Datapath fields may load or hold, but are don't-care.
  4. hazard=1: bubble loaded. bubble_cnt increments and saturates at all-ones.
  5. Otherwise: all id_* fields load with 1-cycle latency, and ex_valid=1 for a valid opcode.
- A bubble never carries RegWrite, MemWrite or MemRead = 1.
- A load-use pair produces exactly one bubble: after the bubble, ex_valid=0, so hazard deasserts and the held instruction issues the next cycle.
- flush and hazard asserted together: the bubble loads but bubble_cnt does not increment (the flush wins).
- Register 0 is never a hazard source.

Test Plan:
- Reset: assert rst asynchronously between edges with ex_* nonzero -> all outputs 0 immediately, bubble_cnt=0, pc_write=1.
- Normal load: id_opcode=000100, rdata1=0x0000_0005, rdata2=0x0000_0003, rs=1, rt=2, rd=3, funct=0x20 -> next edge ex_RegDst=1, ex_RegWrite=1, ex_ALUOp=10, ex_rdata1=5, ex_rd=3, ex_valid=1.
- Load-use on rs: lw with rt=4 in EX, then addi with rs=4 in ID -> pc_write=0, if_id_write=0; next edge bubble (ex_valid=0, ex_RegWrite=0), bubble_cnt=1; following edge addi loads.
- Non-source rt: lw with rt=4 in EX, addi with rt=4 and rs=7 in ID -> no hazard, pc_write=1. Repeat with sw rt=4 -> hazard=1. Repeat with lw rt=0 -> no hazard.
- stall_in: assert stall_in for 3 cycles with a valid instruction in EX -> ex_* unchanged for 3 edges, pc_write=0, bubble_cnt unchanged. Combine with flush=1 -> still held.
- Invalid opcode and saturation: id_opcode=111111 with id_RegWrite=1 -> ex_RegWrite=0, ex_valid=0. Preload bubble_cnt near all-ones via 65535+ hazards (or CNT_W=2 with 4 hazards) -> bubble_cnt stays at all-ones.
